// File: rtl/sniff_pkg.sv
// Shared constants and width helpers for the sniff_fifo block.
package sniff_pkg;

    localparam int unsigned DROP_CNT_W = 8;

    // Level must represent 0..2**aw inclusive, so it needs one extra bit.
    function automatic int unsigned level_w(input int unsigned aw);
        return aw + 1;
    endfunction

    function automatic int unsigned ptr_w(input int unsigned aw);
        return aw;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module fifo_ram
    import sniff_pkg::*;
#(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic                 clock,
    input  logic                 wr_en,
    input  logic [ptr_w(AW)-1:0] wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic                 rd_en,
    input  logic [ptr_w(AW)-1:0] rd_addr,
    output logic [DW-1:0]        rd_data
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];

    // Read-before-write on a shared address: the read sees the old word.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sniff_fifo.sv
// Synchronous FIFO with registered read, level/threshold flags and drop accounting.
module sniff_fifo
    import sniff_pkg::*;
#(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 8,
    parameter int unsigned AF_LEVEL = 2 ** AW - 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    write_en,
    input  logic [DW-1:0]           write_data,
    input  logic                    read_en,
    output logic [DW-1:0]           read_data,
    output logic                    read_valid,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full,
    output logic [level_w(AW)-1:0]  level,
    output logic                    overflow,
    output logic [DROP_CNT_W-1:0]   drop_count,
    input  logic                    clear_overflow
);

    localparam int unsigned LW    = level_w(AW);
    localparam int unsigned PW    = ptr_w(AW);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  read_valid_q;
    logic                  seen_q;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;
    logic [DW-1:0]         ram_q;
    logic                  rd_acc, wr_acc, drop;

    assign empty       = (level_q == '0);
    assign full        = (level_q == LW'(DEPTH));
    assign almost_full = (level_q >= LW'(AF_LEVEL));

    assign rd_acc = read_en && !empty && !flush;
    assign wr_acc = write_en && (!full || rd_acc) && !flush;
    assign drop   = write_en && full && !rd_acc && !flush;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end

        // A drop in the same cycle as a clear restarts the count at one.
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_overflow) begin
                drop_count_d = DROP_CNT_W'(1);
            end else if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + 1'b1;
            end
        end else if (clear_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            read_valid_q <= 1'b0;
            seen_q       <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            read_valid_q <= rd_acc;
            seen_q       <= seen_q || rd_acc;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    fifo_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (write_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_q)
    );

    // The unreset RAM register is masked until the first pop after reset.
    assign read_data  = seen_q ? ram_q : '0;
    assign read_valid = read_valid_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule
